tcam_driver: RTL and testbench

- Clocked initiator for the tcam block's combinational write/search interface.
- Accepts write and search commands over a valid/ready command channel and sequences tcam_write_address, tcam_data, tcam_data_x and tcam_w_r_bar with fixed setup, strobe and hold timing.
- Samples the TCAM's address and match_flag after a settle window and returns them on a valid/ready response channel.
- Sits between the system's lookup logic and a tcam instance.

---
 rtl/tcam_driver.sv | 161 ++++++++++++++++
 tb/tb_tcam_driver.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_driver.sv
// tcam_driver: clocked initiator for a combinational TCAM write/search port.
// Commands arrive on a valid/ready channel. Writes are sequenced with setup,
// strobe and hold phases. Searches drive the key, wait a settle window and
// return the sampled match on a valid/ready response channel.
module tcam_driver #(
    parameter int unsigned N         = 4,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned SETUP     = 1,
    parameter int unsigned WRITE_CYC = 2,
    parameter int unsigned SETTLE    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [N-1:0]         cmd_addr,
    input  logic [WORD_SIZE-1:0] cmd_data,
    input  logic [WORD_SIZE-1:0] cmd_mask,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_addr,
    output logic                 rsp_hit,
    output logic [WORD_SIZE-1:0] tcam_data,
    output logic [WORD_SIZE-1:0] tcam_data_x,
    output logic                 tcam_w_r_bar,
    output logic [N-1:0]         tcam_write_address,
    input  logic [N-1:0]         tcam_address,
    input  logic                 tcam_match_flag
);

    localparam int unsigned MAX_SW  = (SETUP > WRITE_CYC) ? SETUP : WRITE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SW > SETTLE) ? MAX_SW : SETTLE;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_STROBE = 3'd2,
        W_HOLD   = 3'd3,
        S_DRIVE  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 cmd_ready_n;
    logic                 rsp_valid_n;
    logic [N-1:0]         rsp_addr_n;
    logic                 rsp_hit_n;
    logic [WORD_SIZE-1:0] tcam_data_n;
    logic [WORD_SIZE-1:0] tcam_data_x_n;
    logic                 tcam_w_r_bar_n;
    logic [N-1:0]         tcam_write_address_n;

    // State, phase counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            cmd_ready          <= 1'b1;
            rsp_valid          <= 1'b0;
            rsp_addr           <= '0;
            rsp_hit            <= 1'b0;
            tcam_data          <= '0;
            tcam_data_x        <= '0;
            tcam_w_r_bar       <= 1'b0;
            tcam_write_address <= '0;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            cmd_ready          <= cmd_ready_n;
            rsp_valid          <= rsp_valid_n;
            rsp_addr           <= rsp_addr_n;
            rsp_hit            <= rsp_hit_n;
            tcam_data          <= tcam_data_n;
            tcam_data_x        <= tcam_data_x_n;
            tcam_w_r_bar       <= tcam_w_r_bar_n;
            tcam_write_address <= tcam_write_address_n;
        end
    end

    // Next state, counter reload on state entry, and next output values.
    always_comb begin
        state_n              = state;
        cnt_n                = cnt;
        rsp_valid_n          = rsp_valid;
        rsp_addr_n           = rsp_addr;
        rsp_hit_n            = rsp_hit;
        tcam_data_n          = tcam_data;
        tcam_data_x_n        = tcam_data_x;
        tcam_w_r_bar_n       = tcam_w_r_bar;
        tcam_write_address_n = tcam_write_address;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    tcam_data_n   = cmd_data;
                    tcam_data_x_n = cmd_mask;
                    if (cmd_write) begin
                        tcam_write_address_n = cmd_addr;
                        state_n              = W_SETUP;
                        cnt_n                = CW'(SETUP - 1);
                    end else begin
                        state_n = S_DRIVE;
                        cnt_n   = CW'(SETTLE - 1);
                    end
                end
            end
            W_SETUP: begin
                if (cnt == '0) begin
                    tcam_w_r_bar_n = 1'b1;
                    state_n        = W_STROBE;
                    cnt_n          = CW'(WRITE_CYC - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            W_STROBE: begin
                if (cnt == '0) begin
                    tcam_w_r_bar_n = 1'b0;
                    state_n        = W_HOLD;
                    cnt_n          = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            W_HOLD: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            S_DRIVE: begin
                if (cnt == '0) begin
                    rsp_hit_n   = tcam_match_flag;
                    rsp_addr_n  = tcam_match_flag ? tcam_address : '0;
                    rsp_valid_n = 1'b1;
                    state_n     = S_RESP;
                    cnt_n       = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                    cnt_n       = '0;
                end
            end
            default: begin
                state_n        = IDLE;
                cnt_n          = '0;
                tcam_w_r_bar_n = 1'b0;
                rsp_valid_n    = 1'b0;
            end
        endcase

        cmd_ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_tcam_driver.sv
// tb_tcam_driver: table-driven directed vectors, timing sequences and a
// randomized phase checked against an associative-memory reference model.
module tb_tcam_driver;

    localparam int unsigned N         = 4;
    localparam int unsigned WS        = 16;
    localparam int unsigned SETUP     = 1;
    localparam int unsigned WRITE_CYC = 2;
    localparam int unsigned SETTLE    = 2;
    localparam int unsigned DEPTH     = 1 << N;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [N-1:0]  cmd_addr;
    logic [WS-1:0] cmd_data;
    logic [WS-1:0] cmd_mask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_addr;
    logic          rsp_hit;
    logic [WS-1:0] tcam_data;
    logic [WS-1:0] tcam_data_x;
    logic          tcam_w_r_bar;
    logic [N-1:0]  tcam_write_address;
    logic [N-1:0]  tcam_address;
    logic          tcam_match_flag;

    int errors = 0;
    int checks = 0;

    tcam_driver #(
        .N(N), .WORD_SIZE(WS), .SETUP(SETUP), .WRITE_CYC(WRITE_CYC), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_hit(rsp_hit),
        .tcam_data(tcam_data), .tcam_data_x(tcam_data_x), .tcam_w_r_bar(tcam_w_r_bar),
        .tcam_write_address(tcam_write_address), .tcam_address(tcam_address),
        .tcam_match_flag(tcam_match_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ternary match: bits differing from the key matter unless masked on either side.
    function automatic bit entry_match(input logic [WS-1:0] ed, input logic [WS-1:0] em,
                                       input logic [WS-1:0] key, input logic [WS-1:0] km);
        return ((ed ^ key) & ~(em | km)) == '0;
    endfunction

    // Environment TCAM: level-sensitive write sampled per clock, lowest index wins.
    logic [WS-1:0] t_data [DEPTH];
    logic [WS-1:0] t_mask [DEPTH];
    bit            t_valid[DEPTH];

    initial for (int i = 0; i < DEPTH; i++) begin
        t_valid[i] = 1'b0; t_data[i] = '0; t_mask[i] = '0;
    end

    always @(posedge clk) begin
        if (tcam_w_r_bar) begin
            t_data[tcam_write_address]  <= tcam_data;
            t_mask[tcam_write_address]  <= tcam_data_x;
            t_valid[tcam_write_address] <= 1'b1;
        end
    end

    // Miss drives a non-zero address so the driver's zeroing on miss is observable.
    always_comb begin
        tcam_address    = 4'hA;
        tcam_match_flag = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (t_valid[i] && entry_match(t_data[i], t_mask[i], tcam_data, tcam_data_x)) begin
                tcam_address    = N'(i);
                tcam_match_flag = 1'b1;
            end
        end
    end

    // Reference model: what the issued commands say the table should hold.
    logic [WS-1:0] r_data [DEPTH];
    logic [WS-1:0] r_mask [DEPTH];
    bit            r_valid[DEPTH];

    task automatic ref_search(input logic [WS-1:0] key, input logic [WS-1:0] km,
                              output bit hit, output logic [N-1:0] a);
        hit = 1'b0;
        a   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && r_valid[i] && entry_match(r_data[i], r_mask[i], key, km)) begin
                hit = 1'b1;
                a   = N'(i);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command and check its full cycle-level behaviour.
    task automatic do_cmd(input bit wr, input logic [N-1:0] addr, input logic [WS-1:0] data,
                          input logic [WS-1:0] mask, input bit exp_hit,
                          input logic [N-1:0] exp_addr, input int bp);
        logic [N-1:0] old_waddr;
        int bad_strobe, bad_stable, bad_misc, bad_hold;
        logic [N-1:0] snap_addr;
        logic snap_hit;
        wait_ready();
        old_waddr = tcam_write_address;
        cmd_write = wr; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
        cmd_valid = 1'b1;
        rsp_ready = (bp == 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        bad_strobe = 0; bad_stable = 0; bad_misc = 0; bad_hold = 0;
        if (wr) begin
            for (int p = 0; p <= int'(SETUP + WRITE_CYC); p++) begin
                if (p > 0) @(negedge clk);
                if (tcam_w_r_bar !== (p >= int'(SETUP) && p < int'(SETUP + WRITE_CYC))) bad_strobe++;
                if (tcam_write_address !== addr || tcam_data !== data || tcam_data_x !== mask) bad_stable++;
                if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) bad_misc++;
            end
            @(negedge clk);
            check("write_strobe_pattern", 32'(bad_strobe), 32'd0);
            check("write_addr_data_stable", 32'(bad_stable), 32'd0);
            check("write_no_rsp_not_ready", 32'(bad_misc), 32'd0);
            check("write_ready_return", 32'(cmd_ready), 32'd1);
            check("write_no_rsp_end", 32'(rsp_valid), 32'd0);
            r_data[addr] = data; r_mask[addr] = mask; r_valid[addr] = 1'b1;
        end else begin
            for (int p = 0; p < int'(SETTLE); p++) begin
                if (p > 0) @(negedge clk);
                if (rsp_valid || cmd_ready || tcam_w_r_bar || tcam_data !== data ||
                    tcam_data_x !== mask || tcam_write_address !== old_waddr) bad_misc++;
            end
            @(negedge clk);
            check("search_drive_phase", 32'(bad_misc), 32'd0);
            check("search_rsp_valid_latency", 32'(rsp_valid), 32'd1);
            check("search_rsp_hit", 32'(rsp_hit), 32'(exp_hit));
            check("search_rsp_addr", 32'(rsp_addr), 32'(exp_addr));
            snap_addr = rsp_addr;
            snap_hit  = rsp_hit;
            if (bp > 0) begin
                for (int k = 0; k < bp; k++) begin
                    @(negedge clk);
                    if (rsp_valid !== 1'b1 || rsp_addr !== snap_addr ||
                        rsp_hit !== snap_hit || cmd_ready !== 1'b0) bad_hold++;
                end
                check("backpressure_hold", 32'(bad_hold), 32'd0);
                rsp_ready = 1'b1;
            end
            @(negedge clk);
            check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
            check("ready_after_rsp", 32'(cmd_ready), 32'd1);
        end
    endtask

    typedef struct {
        bit            wr;
        logic [N-1:0]  addr;
        logic [WS-1:0] data;
        logic [WS-1:0] mask;
        bit            hit;
        logic [N-1:0]  raddr;
        int            bp;
    } vec_t;

    function automatic vec_t mk(input bit wr, input int addr, input int data, input int mask,
                                input bit hit, input int raddr, input int bp);
        vec_t v;
        v.wr = wr; v.addr = N'(addr); v.data = WS'(data); v.mask = WS'(mask);
        v.hit = hit; v.raddr = N'(raddr); v.bp = bp;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        bit eh;
        logic [N-1:0] ea;
        bit wr;
        logic [N-1:0] a;
        logic [WS-1:0] d, m;

        for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] = 1'b0; r_data[i] = '0; r_mask[i] = '0;
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_addr", 32'(rsp_addr), 32'd0);
        check("reset_rsp_hit", 32'(rsp_hit), 32'd0);
        check("reset_tcam_data", 32'(tcam_data), 32'd0);
        check("reset_tcam_data_x", 32'(tcam_data_x), 32'd0);
        check("reset_w_r_bar", 32'(tcam_w_r_bar), 32'd0);
        check("reset_write_address", 32'(tcam_write_address), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        tbl.push_back(mk(1, 0, 10, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 20, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 30, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 40, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 30, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 40, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 10, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 20, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 50, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 'h0008, 'h0020, 1, 3, 0));
        tbl.push_back(mk(1, 3, 'h0008, 'h0020, 0, 0, 0));
        tbl.push_back(mk(0, 0, 40, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 8, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 6, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 30, 0, 1, 2, 5));
        tbl.push_back(mk(0, 0, 50, 0, 0, 0, 3));

        foreach (tbl[i])
            do_cmd(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].mask,
                   tbl[i].hit, tbl[i].raddr, tbl[i].bp);

        // Reset in the middle of a write strobe.
        wait_ready();
        cmd_write = 1'b1; cmd_addr = 4'd7; cmd_data = 16'h0BEE; cmd_mask = '0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        repeat (SETUP) @(negedge clk);
        check("strobe_before_reset", 32'(tcam_w_r_bar), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("reset_async_w_r_bar", 32'(tcam_w_r_bar), 32'd0);
        check("reset_async_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_async_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        r_data[7] = t_data[7]; r_mask[7] = t_mask[7]; r_valid[7] = t_valid[7];
        do_cmd(1'b0, '0, 16'd20, '0, 1'b1, 4'd1, 0);
        do_cmd(1'b0, '0, 16'd30, '0, 1'b1, 4'd2, 0);

        // Randomized mix, expectations from the reference model.
        for (int i = 0; i < 60; i++) begin
            wr = ($urandom_range(0, 2) == 0);
            a  = N'($urandom_range(0, DEPTH - 1));
            d  = WS'($urandom_range(0, 31));
            m  = ($urandom_range(0, 3) == 0) ? WS'(1 << $urandom_range(0, 4)) : '0;
            if (wr) begin
                do_cmd(1'b1, a, d, m, 1'b0, '0, 0);
            end else begin
                ref_search(d, m, eh, ea);
                do_cmd(1'b0, a, d, m, eh, ea, int'($urandom_range(0, 2)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
